// File: rtl/ip_pkg.sv
// Shared types for the ip_in_fifo input buffer: frame FSM states, word modes and error-bit indices.
package ip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } frame_state_t;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_A    = 2'd1,
        MODE_B    = 2'd2,
        MODE_C    = 2'd3
    } mode_t;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_MISMATCH = 1;

    function automatic logic mode_is_valid(input logic [1:0] mode);
        return mode != MODE_NONE;
    endfunction

endpackage

// File: rtl/ip_fifo_mem.sv
// Storage array for ip_in_fifo: DEPTH entries of {data, mode, last}, synchronous write, combinational read.
module ip_fifo_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW+2:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW+2:0]            rd_data
);

    logic [DW+2:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ip_in_fifo.sv
// Frame-aware input FIFO between the upstream arbiter and the processing engine.
// Define IP_IN_FIFO_FWFT_EN for first-word-fall-through; otherwise the output stage is registered.
module ip_in_fifo
    import ip_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int SKID  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DW-1:0]          slvx_data,
    input  logic                   slvx_data_valid,
    input  logic [1:0]             slvx_mode,
    input  logic                   slvx_proc_val,
    output logic                   fifo_threshold,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic [DW-1:0]          out_data,
    output logic [1:0]             out_mode,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [1:0]             err_sticky,
    output frame_state_t           frame_state
);

    // Handshake: a write is taken on an edge where slvx_data_valid=1 with a non-zero mode and
    // the frame FSM admits it; a read completes on an edge where out_valid=1 and out_ready=1.

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DW + 3;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] THR_LEVEL  = LW'(DEPTH - SKID);
    localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_next;
    frame_state_t  state_q;
    logic [1:0]    frame_mode_q;
    logic [1:0]    err_q;
    logic          thr_q;
    logic          out_valid_q;
    logic          out_valid_next;
    logic          wr_en;
    logic          mem_pop;
    logic          rd_fire;
    logic          mem_empty;
    logic          has_space;
    logic          set_ovf;
    logic          set_mis;
    logic [EW-1:0] mem_rdata;

    assign rd_fire    = out_valid_q && out_ready;
    assign mem_empty  = (wr_ptr == rd_ptr);
    assign has_space  = (level_q != FULL_LEVEL) || rd_fire;
    assign level_next = level_q + LW'(wr_en) - LW'(rd_fire);

    // Mode mismatch takes precedence over overflow; FLUSH silently drops everything.
    always_comb begin
        wr_en   = 1'b0;
        set_ovf = 1'b0;
        set_mis = 1'b0;
        if (slvx_data_valid && mode_is_valid(slvx_mode)) begin
            case (state_q)
                ST_IDLE: begin
                    if (has_space) wr_en = 1'b1;
                    else           set_ovf = 1'b1;
                end
                ST_ACTIVE: begin
                    if (slvx_mode != frame_mode_q) set_mis = 1'b1;
                    else if (has_space)            wr_en = 1'b1;
                    else                           set_ovf = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            state_q      <= ST_IDLE;
            frame_mode_q <= '0;
            err_q        <= '0;
            thr_q        <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            if (wr_en)   wr_ptr <= wr_ptr + PTR_ONE;
            if (mem_pop) rd_ptr <= rd_ptr + PTR_ONE;
            level_q     <= level_next;
            thr_q       <= (level_next >= THR_LEVEL);
            out_valid_q <= out_valid_next;
            if (set_ovf) err_q[ERR_OVERFLOW] <= 1'b1;
            if (set_mis) err_q[ERR_MISMATCH] <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (wr_en) begin
                        frame_mode_q <= slvx_mode;
                        state_q      <= slvx_proc_val ? ST_FLUSH : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: if (wr_en && slvx_proc_val) state_q <= ST_FLUSH;
                ST_FLUSH:  if (rd_fire && out_last)    state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    ip_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({slvx_data, slvx_mode, slvx_proc_val}),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rdata)
    );

`ifdef IP_IN_FIFO_FWFT_EN
    // Head of storage is presented directly; level is the storage count.
    assign mem_pop        = rd_fire;
    assign out_valid_next = (level_next != '0);
    assign out_data       = out_valid_q ? mem_rdata[EW-1:3] : '0;
    assign out_mode       = out_valid_q ? mem_rdata[2:1] : 2'b00;
    assign out_last       = out_valid_q & mem_rdata[0];
`else
    // Output register refills from storage whenever it is empty or being read.
    logic [EW-1:0] out_q;

    assign mem_pop        = (!out_valid_q || rd_fire) && !mem_empty;
    assign out_valid_next = mem_pop || (out_valid_q && !rd_fire);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (mem_pop) begin
            out_q <= mem_rdata;
        end
    end

    assign out_data = out_q[EW-1:3];
    assign out_mode = out_q[2:1];
    assign out_last = out_q[0];
`endif

    assign out_valid      = out_valid_q;
    assign fifo_empty     = !out_valid_q;
    assign fifo_full      = (level_q == FULL_LEVEL);
    assign fifo_threshold = thr_q;
    assign level          = level_q;
    assign err_sticky     = err_q;
    assign frame_state    = state_q;

endmodule

// File: tb/tb_ip_in_fifo.sv
// Bench for ip_in_fifo: directed frame scenarios plus random traffic against a queue-based model.
module tb_ip_in_fifo;
    import ip_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int SKID  = 3;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef IP_IN_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] slvx_data = '0;
    logic          slvx_data_valid = 1'b0;
    logic [1:0]    slvx_mode = '0;
    logic          slvx_proc_val = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_threshold, fifo_empty, fifo_full;
    logic [DW-1:0] out_data;
    logic [1:0]    out_mode;
    logic          out_last, out_valid;
    logic [LW-1:0] level;
    logic [1:0]    err_sticky;
    frame_state_t  frame_state;

    ip_in_fifo #(.DW(DW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .slvx_data       (slvx_data),
        .slvx_data_valid (slvx_data_valid),
        .slvx_mode       (slvx_mode),
        .slvx_proc_val   (slvx_proc_val),
        .fifo_threshold  (fifo_threshold),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .out_data        (out_data),
        .out_mode        (out_mode),
        .out_last        (out_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .level           (level),
        .err_sticky      (err_sticky),
        .frame_state     (frame_state)
    );

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    m;
        logic          l;
        int unsigned   wc;
    } ent_t;

    ent_t         exp_q[$];
    frame_state_t m_state = ST_IDLE;
    logic [1:0]   m_fmode = '0;
    logic [1:0]   m_err = '0;
    logic         m_thr = 1'b0;
    int unsigned  edge_n = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Head is presented at once in FWFT, otherwise only once it was stored before the last edge.
    function automatic bit m_valid();
        if (exp_q.size() == 0) return 1'b0;
        if (FWFT) return 1'b1;
        return exp_q[0].wc < edge_n;
    endfunction

    task automatic model_edge();
        bit   rd;
        bit   wr;
        ent_t e;
        rd = m_valid() && out_ready;
        wr = 1'b0;
        edge_n++;
        if (!rst_n) begin
            exp_q.delete();
            m_state = ST_IDLE;
            m_fmode = '0;
            m_err   = '0;
            m_thr   = 1'b0;
            return;
        end
        if (slvx_data_valid && slvx_mode != 2'd0) begin
            if (m_state == ST_ACTIVE && slvx_mode != m_fmode) m_err[1] = 1'b1;
            else if (m_state != ST_FLUSH) begin
                if (exp_q.size() < DEPTH || rd) wr = 1'b1;
                else m_err[0] = 1'b1;
            end
        end
        if (rd) begin
            e = exp_q.pop_front();
            if (e.l && m_state == ST_FLUSH) m_state = ST_IDLE;
        end
        if (wr) begin
            e.d = slvx_data; e.m = slvx_mode; e.l = slvx_proc_val; e.wc = edge_n;
            exp_q.push_back(e);
            if (m_state == ST_IDLE) begin
                m_fmode = slvx_mode;
                m_state = slvx_proc_val ? ST_FLUSH : ST_ACTIVE;
            end else if (slvx_proc_val) begin
                m_state = ST_FLUSH;
            end
        end
        m_thr = (exp_q.size() >= DEPTH - SKID);
    endtask

    task automatic compare_all();
        check("level", level, exp_q.size());
        check("out_valid", out_valid, m_valid());
        check("fifo_empty", fifo_empty, !m_valid());
        check("fifo_full", fifo_full, exp_q.size() == DEPTH);
        check("fifo_threshold", fifo_threshold, m_thr);
        check("err_sticky", err_sticky, m_err);
        check("frame_state", frame_state, m_state);
        if (m_valid()) begin
            check("out_data", out_data, exp_q[0].d);
            check("out_mode", out_mode, exp_q[0].m);
            check("out_last", out_last, exp_q[0].l);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [1:0] m,
                         input logic l, input logic rdy);
        slvx_data_valid = v;
        slvx_data       = d;
        slvx_mode       = m;
        slvx_proc_val   = l;
        out_ready       = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] words[4];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    logic [DW-1:0] rnd_d;
    logic [1:0]    rnd_m;
    int            rdy_pct;

    initial begin
        // Reset with a write presented in the same cycle: the write must be ignored.
        rst_n = 1'b0;
        drive(1'b1, 32'hdead_beef, 2'd1, 1'b0, 1'b0);
        step();
        step();
        check("rst_out_data", out_data, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
        step();

        // Fill without reads, then one write too many.
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, $urandom, MODE_A, 1'b0, 1'b0);
            step();
            if (i == 12) check("thr_before_13", fifo_threshold, 0);
            if (i == 13) check("thr_at_13", fifo_threshold, 1);
            if (i == 16) check("full_at_16", fifo_full, 1);
        end
        check("level_after_17", level, 16);
        check("err_after_17", err_sticky, 2'b01);

        // Simultaneous read and write while full.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, $urandom, MODE_A, 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, MODE_A, 1'b0, 1'b1);
            step();
            check("full_rw_level", level, 16);
            check("full_rw_err", err_sticky, 2'b00);
        end

        // Simultaneous read and write from empty: streaming settles at a constant level.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, $urandom, MODE_B, 1'b0, 1'b1);
            step();
            check("empty_rw_err", err_sticky, 2'b00);
            if (i >= 2) check("empty_rw_level", level, FWFT ? 1 : 2);
        end

        // Four-word frame, mode 2, last on word 4, out_ready held high.
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) drive(1'b1, words[c], MODE_B, c == 3, 1'b1);
            else       drive(1'b0, '0, 2'd0, 1'b0, 1'b1);
            if (out_valid) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            step();
            if (got_d.size() == 4) break;
        end
        check("frame_read_count", got_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_d.size()) begin
                check("frame_word", got_d[i], words[i]);
                check("frame_last", got_l[i], i == 3);
            end
        end
        check("frame_idle", frame_state, ST_IDLE);

        // Mode mismatch while ACTIVE.
        do_reset();
        drive(1'b1, $urandom, MODE_A, 1'b0, 1'b0);
        step();
        drive(1'b1, $urandom, MODE_B, 1'b0, 1'b0);
        step();
        check("mismatch_level", level, 1);
        check("mismatch_err", err_sticky[1], 1);

        // Reset mid-frame at level 7.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, $urandom, MODE_C, 1'b0, 1'b0);
            step();
        end
        check("midframe_level", level, 7);
        rst_n = 1'b0;
        drive(1'b1, $urandom, MODE_C, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        check("midrst_level", level, 0);
        check("midrst_empty", fifo_empty, 1);
        check("midrst_valid", out_valid, 0);
        check("midrst_state", frame_state, ST_IDLE);

        // Latency of a single write.
        drive(1'b1, $urandom, MODE_A, 1'b0, 1'b0);
        step();
        check("latency_edge_n", out_valid, FWFT);
        drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
        step();
        check("latency_edge_n1", out_valid, 1);

        // Random traffic with occasional resets.
        do_reset();
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) rdy_pct = $urandom_range(0, 100);
            rst_n = ($urandom_range(0, 299) != 0);
            rnd_d = $urandom;
            rnd_m = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            drive($urandom_range(0, 3) != 0, rnd_d, rnd_m, $urandom_range(0, 11) == 0,
                  $urandom_range(1, 100) <= rdy_pct);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
